// File: rtl/div_restoring_seq.sv
// Multi-cycle unsigned restoring divider: one shift/trial-subtract per clock,
// start/done handshake, results held until the next division completes.
module div_restoring_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_w_q, quo_w_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic [2*WIDTH-1:0] step;

    // One restoring iteration. The trial value is WIDTH+1 bits so the borrow
    // survives all-ones operands; the restored remainder is always below the
    // divisor, so only WIDTH bits of it need to be kept between iterations.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [WIDTH-1:0] r,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH:0]   r_sh;
        logic [WIDTH-1:0] q_sh;
        r_sh = {r, q[WIDTH-1]};
        q_sh = {q[WIDTH-2:0], 1'b0};
        if (r_sh >= {1'b0, d}) begin
            r_sh    = r_sh - {1'b0, d};
            q_sh[0] = 1'b1;
        end
        return {r_sh[WIDTH-1:0], q_sh};
    endfunction

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_w_d     = quo_w_q;
        dsr_d       = dsr_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        step        = div_step(rem_q, quo_w_q, dsr_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    dsr_d   = divisor;
                    quo_w_d = dividend;
                    rem_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    if (divisor != '0) begin
                        state_d = CALC;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                {rem_d, quo_w_d} = step;
                cnt_d            = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
                // A zero divisor skipped CALC, so the working quotient still
                // holds the original dividend.
                if (dsr_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = quo_w_q;
                    dbz_d       = 1'b1;
                end else begin
                    quotient_d  = quo_w_q;
                    remainder_d = rem_q;
                    dbz_d       = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_w_q     <= '0;
            dsr_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_w_q     <= quo_w_d;
            dsr_q       <= dsr_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_restoring_seq.sv
// Scoreboard bench for div_restoring_seq (WIDTH=4): directed vectors push
// expected results; a negedge monitor pops and compares on every done pulse.
module tb_div_restoring_seq;

    typedef struct packed {
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy, done, div_by_zero;
    logic [3:0] quotient, remainder;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    exp_t prev_exp = '0;

    div_restoring_seq #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] q, input logic [3:0] r, input logic z);
        exp_t e;
        e.q = q;
        e.r = r;
        e.z = z;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mon_quotient", 32'(quotient), 32'(e.q));
                check("mon_remainder", 32'(remainder), 32'(e.r));
                check("mon_div_by_zero", 32'(div_by_zero), 32'(e.z));
            end
        end
    end

    // Issue one division, scramble operands after acceptance, and measure
    // done latency and busy duration in cycles after the accepting edge.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input exp_t e,
                          input int exp_lat, input int exp_busy);
        int n;
        int bc;
        @(negedge clk);
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(posedge clk);
        sb.push_back(e);
        #1;
        start = 1'b0;
        dividend = ~a;
        divisor = ~b;
        n = 0;
        bc = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("hold_quotient", 32'(quotient), 32'(prev_exp.q));
                check("hold_remainder", 32'(remainder), 32'(prev_exp.r));
                check("hold_div_by_zero", 32'(div_by_zero), 32'(prev_exp.z));
            end
            if (busy) bc++;
            if (done) break;
        end
        check("done_latency", 32'(n), 32'(exp_lat));
        check("busy_cycles", 32'(bc), 32'(exp_busy));
        prev_exp = e;
    endtask

    initial begin
        int dones;
        int gap;

        #3;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_quotient", 32'(quotient), 0);
        check("rst_remainder", 32'(remainder), 0);
        check("rst_div_by_zero", 32'(div_by_zero), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(4'hD, 4'h4, mk(4'h3, 4'h1, 1'b0), 6, 4);
        run_op(4'hF, 4'h1, mk(4'hF, 4'h0, 1'b0), 6, 4);
        run_op(4'h7, 4'h9, mk(4'h0, 4'h7, 1'b0), 6, 4);
        run_op(4'h0, 4'h5, mk(4'h0, 4'h0, 1'b0), 6, 4);
        run_op(4'hF, 4'hF, mk(4'h1, 4'h0, 1'b0), 6, 4);
        run_op(4'hB, 4'h0, mk(4'hF, 4'hB, 1'b1), 2, 0);
        run_op(4'h8, 4'h2, mk(4'h4, 4'h0, 1'b0), 6, 4);

        // Start during CALC must be ignored and yield exactly one done.
        @(negedge clk);
        start = 1'b1;
        dividend = 4'hC;
        divisor = 4'h5;
        @(posedge clk);
        sb.push_back(mk(4'h2, 4'h2, 1'b0));
        #1;
        start = 1'b0;
        dones = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 2) begin
                start = 1'b1;
                dividend = 4'h9;
                divisor = 4'h3;
            end
            if (c == 3) start = 1'b0;
            if (done) dones++;
        end
        check("ignored_start_done_count", 32'(dones), 1);
        prev_exp = mk(4'h2, 4'h2, 1'b0);

        // Asynchronous reset two cycles into CALC aborts the division.
        @(negedge clk);
        start = 1'b1;
        dividend = 4'hC;
        divisor = 4'h5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_quotient", 32'(quotient), 0);
        check("midrst_remainder", 32'(remainder), 0);
        check("midrst_div_by_zero", 32'(div_by_zero), 0);
        prev_exp = '0;
        dones = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) dones++;
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrst_no_done", 32'(dones), 0);
        run_op(4'h9, 4'h2, mk(4'h4, 4'h1, 1'b0), 6, 4);

        // Sweep all operand pairs with start held high throughout.
        for (int i = 0; i < 256; i++) begin
            logic [3:0] a;
            logic [3:0] b;
            a = 4'(i >> 4);
            b = 4'(i);
            @(negedge clk);
            start = 1'b1;
            dividend = a;
            divisor = b;
            @(posedge clk);
            if (b == 4'h0) sb.push_back(mk(4'hF, a, 1'b1));
            else sb.push_back(mk(a / b, a % b, 1'b0));
            gap = (b == 4'h0) ? 2 : 6;
            repeat (gap - 1) @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
